fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the decode stage, where opcode, immediate extraction and register select happen.
- Keeps the word-addressed PC and issues requests to a fixed 1-cycle-latency instruction memory.
- Buffers returned 32-bit instructions, each with its PC, in a small credit-controlled FIFO.
- Presents them to decode over a valid/ready handshake.
- On a redirect (branch/jump resolved downstream), flushes all buffered and in-flight instructions and restarts at the new PC.

Parameters:
PC_W, 16, width of word-addressed PC and imem address
FIFO_DEPTH, 4, instruction buffer entries; power of 2, minimum 4

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
fetch_en  input  1  when 0, no new memory requests are issued; the buffer still drains
imem_req  output  1  memory read request this cycle
imem_addr  output  PC_W  word address for imem_req
imem_rdata  input  32  instruction word; valid exactly 1 cycle after imem_req
redirect_valid  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  PC_W  redirect target (word address)
instr_valid  output  1  instr_out/pc_out hold a valid instruction
instr_ready  input  1  decode accepts the head instruction
instr_out  output  32  head instruction word (instr[31:29] = opcode)
pc_out  output  PC_W  PC of the head instruction

Behaviour:
- Reset (asynchronous, active-high):
  - pc=0, FIFO empty (count=0, rd/wr pointers 0), inflight=0.
  - instr_valid=0, instr_out=0, pc_out=0, imem_req=0.
- Request rule (redirect_valid=0):
  - imem_req = fetch_en && (count + inflight < FIFO_DEPTH).
  - count and inflight are the registered values of the current cycle.
  - imem_addr = pc.
  - On issue: pc <= pc+1, wrapping modulo 2^PC_W; inflight <= 1. Otherwise inflight <= 0.
- Response:
  - If inflight=1 in a cycle and redirect_valid=0, push {imem_rdata, pc of the request} into the FIFO that cycle.
  - The credit rule guarantees a push never overflows. The bench asserts no push while count==FIFO_DEPTH.
- Output:
  - instr_valid = (count != 0) && !redirect_valid.
  - instr_out/pc_out show the FIFO head, registered storage with a combinational read.
  - When empty, both are 0.
  - Pop when instr_valid && instr_ready.
  - Push and pop in the same cycle are allowed: count unchanged, pointers each advance and wrap modulo FIFO_DEPTH.
- Latency and throughput:
  - First request in the first cycle after reset deasserts.
  - That instruction is visible at the output 2 cycles after its request.
  - With instr_ready held high, steady state is 1 instruction/cycle.
- Redirect (redirect_valid=1), fetch_en and credits ignored:
  - FIFO flushed: count <= 0, pointers reset.
  - Any response arriving this cycle is discarded.
  - instr_valid forced 0; no pop occurs.
  - imem_req=1, imem_addr=redirect_pc; pc <= redirect_pc+1; inflight <= 1.
  - The redirected instruction is pushed the next cycle and is visible on the cycle after that.
- Back-to-back redirects: each redirect discards the previous cycle's response. Only the last target's stream survives.
- fetch_en deassert: a pending inflight response is still pushed; no further requests are issued.
- Reset mid-operation: all state clears immediately. A memory response following reset is ignored because inflight=0.

Optional Feature:
FETCH_STALL_CNT_EN
- Defined: adds output port stall_cnt (32-bit, reset 0).
  - Increments by 1 every cycle with instr_valid && !instr_ready.
  - Saturates at 0xFFFFFFFF.
  - Not cleared by redirect.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
1. Reset release, fetch_en=1, instr_ready=1, memory returns 0x20000000+addr:
   - imem_addr 0,1,2… on consecutive cycles.
   - instr_valid first high 2 cycles after the first request with pc_out=0, instr_out=0x20000000.
   - Then one instruction per cycle, pc_out incrementing.
2. instr_ready=0 from the start:
   - Exactly 4 requests issued (addr 0..3), then imem_req stays 0.
   - Head holds pc_out=0.
   - Raising instr_ready drains PCs 0,1,2,3 in order and requests resume at addr 4.
3. Steady streaming, then redirect_valid=1 with redirect_pc=0x0100 for one cycle:
   - That cycle: instr_valid=0, imem_addr=0x0100.
   - Next output is pc_out=0x0100 two cycles later.
   - No pre-redirect PC ever appears afterwards.
4. Redirects on two consecutive cycles (0x0040 then 0x0080):
   - Only PCs 0x0080, 0x0081… emerge; 0x0040 is never output.
5. PC_W=16, redirect_pc=0xFFFF:
   - Outputs pc_out 0xFFFF then 0x0000 (wrap).
6. FETCH_STALL_CNT_EN defined, 5 cycles of valid && !ready, then ready:
   - stall_cnt=5 and holds.
7. Assert rst mid-stream:
   - Outputs 0 immediately (asynchronous).
   - After release, fetch restarts at addr 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, 1-cycle imem requests, credit-controlled
// instruction FIFO towards decode. Optional build macro: FETCH_STALL_CNT_EN (adds stall_cnt).
module fetch_unit #(
    parameter int PC_W       = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr_out,
    output logic [PC_W-1:0] pc_out
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int USED_W = CNT_W + 1;
    localparam logic [USED_W-1:0] DEPTH_U = USED_W'(FIFO_DEPTH);
    localparam logic [PC_W-1:0]   PC_ONE  = PC_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);

    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  r_req_pc;
    logic             r_inflight;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [31:0]      r_instr_mem [FIFO_DEPTH];
    logic [PC_W-1:0]  r_pc_mem    [FIFO_DEPTH];

    logic [USED_W-1:0] w_used;
    logic              w_credit_ok;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_nonempty;

    // The in-flight request reserves a FIFO slot, so a response can always be accepted.
    assign w_used      = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_credit_ok = (w_used < DEPTH_U);
    assign w_issue     = !rst && (redirect_valid || (fetch_en && w_credit_ok));
    assign w_push      = r_inflight && !redirect_valid;
    assign w_nonempty  = (r_count != '0);

    assign imem_req  = w_issue;
    assign imem_addr = redirect_valid ? redirect_pc : r_pc;

    // Decode handshake: the head is transferred on a cycle where instr_valid && instr_ready;
    // instr_valid never depends on instr_ready, and a redirect suppresses it.
    assign instr_valid = w_nonempty && !redirect_valid;
    assign w_pop       = instr_valid && instr_ready;
    assign instr_out   = w_nonempty ? r_instr_mem[r_rd_ptr] : 32'h0;
    assign pc_out      = w_nonempty ? r_pc_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= imem_rdata;
            r_pc_mem[r_wr_ptr]    <= r_req_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= '0;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_inflight <= w_issue;
            if (redirect_valid) begin
                r_pc     <= redirect_pc + PC_ONE;
                r_req_pc <= redirect_pc;
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_issue) begin
                    r_pc     <= r_pc + PC_ONE;
                    r_req_pc <= r_pc;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CNT_ONE;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - CNT_ONE;
                end
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of cycles where decode holds off a valid instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 32'h0;
        end else if (instr_valid && !instr_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'h1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: reference scoreboard of expected {instr, pc}
// plus directed checks for latency, credits, redirects, PC wrap, stall count and reset.
module tb_fetch_unit;

    localparam int PC_W  = 16;
    localparam int DEPTH = 4;

    logic            clk;
    logic            rst;
    logic            fetch_en;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr_out;
    logic [PC_W-1:0] pc_out;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0]     stall_cnt;
`endif

    fetch_unit #(.PC_W(PC_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .pc_out         (pc_out)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within budget");
        $fatal(1, "timeout");
    end

    // ---------------- memory model: 1-cycle latency ----------------
    initial imem_rdata = 32'h0;
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= 32'h2000_0000 + {16'h0, imem_addr};
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [47:0]     exp_q[$];
    logic            pend_v    = 1'b0;
    logic [PC_W-1:0] pend_a    = '0;
    logic [PC_W-1:0] exp_pc    = '0;
    int              req_cnt   = 0;
    logic [31:0]     exp_stall = 32'h0;

    always @(negedge clk) begin
        int   sz;
        logic want_req;
        #1;
        if (rst) begin
            chk("rst_req",   48'(imem_req),    48'(0));
            chk("rst_valid", 48'(instr_valid), 48'(0));
            chk("rst_out",   {instr_out, pc_out}, 48'(0));
`ifdef FETCH_STALL_CNT_EN
            chk("rst_stall", 48'(stall_cnt), 48'(0));
`endif
            exp_q.delete();
            pend_v    = 1'b0;
            exp_pc    = '0;
            req_cnt   = 0;
            exp_stall = 32'h0;
        end else begin
            sz = exp_q.size();
            if (dut.w_push) chk("no_ovf", 48'(dut.r_count == 3'd4), 48'(0));
`ifdef FETCH_STALL_CNT_EN
            chk("stall_cnt", 48'(stall_cnt), 48'(exp_stall));
            if (sz != 0 && !instr_ready && !redirect_valid && exp_stall != 32'hFFFF_FFFF)
                exp_stall = exp_stall + 32'h1;
`endif
            if (redirect_valid) begin
                chk("redir_valid", 48'(instr_valid), 48'(0));
                chk("redir_req",   48'(imem_req),    48'(1));
                chk("redir_addr",  48'(imem_addr),   48'(redirect_pc));
                exp_q.delete();
                pend_v = 1'b1;
                pend_a = redirect_pc;
                exp_pc = redirect_pc + 16'h1;
            end else begin
                if (sz != 0) begin
                    chk("valid_hi", 48'(instr_valid), 48'(1));
                    chk("head", {instr_out, pc_out}, exp_q[0]);
                    if (instr_ready) void'(exp_q.pop_front());
                end else begin
                    chk("valid_lo", 48'(instr_valid), 48'(0));
                    chk("head_zero", {instr_out, pc_out}, 48'(0));
                end
                want_req = fetch_en && ((sz + int'(pend_v)) < DEPTH);
                if (pend_v) exp_q.push_back({32'h2000_0000 + {16'h0, pend_a}, pend_a});
                pend_v = 1'b0;
                chk("req", 48'(imem_req), 48'(want_req));
                if (want_req) begin
                    chk("addr", 48'(imem_addr), 48'(exp_pc));
                    pend_v  = 1'b1;
                    pend_a  = exp_pc;
                    exp_pc  = exp_pc + 16'h1;
                    req_cnt = req_cnt + 1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        run_cycles(n);
    endtask

    // ---------------- stimulus ----------------
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_base;
`endif

    initial begin
        rst            = 1'b1;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        run_cycles(3);

        // 1: streaming from reset, 2-cycle latency, 1 instr/cycle
        @(negedge clk);
        rst = 1'b0; fetch_en = 1'b1; instr_ready = 1'b1;
        #2 chk("t1_first_req", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 16'h0000});
        @(negedge clk);
        #2 chk("t1_not_yet", 48'(instr_valid), 48'(0));
        @(negedge clk);
        #2 chk("t1_latency", {15'h0, instr_valid, instr_out}, {15'h0, 1'b1, 32'h2000_0000});
        chk("t1_pc0", 48'(pc_out), 48'(0));
        @(negedge clk);
        #2 chk("t1_pc1", 48'(pc_out), 48'(1));
        run_cycles(15);

        // 2: decode stalled from reset, credits stop at FIFO_DEPTH
        do_reset(2);
        instr_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_cycles(12);
        #2 chk("t2_reqs", 48'(req_cnt), 48'(4));
        chk("t2_head", {31'h0, instr_valid, pc_out}, {31'h0, 1'b1, 16'h0000});
        @(negedge clk);
        instr_ready = 1'b1;
        run_cycles(12);

        // 3: single redirect mid-stream
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 16'h0100;
        #2 chk("t3_valid", 48'(instr_valid), 48'(0));
        chk("t3_addr", 48'(imem_addr), 48'h0100);
        @(negedge clk);
        redirect_valid = 1'b0;
        #2 chk("t3_gap", 48'(instr_valid), 48'(0));
        @(negedge clk);
        #2 chk("t3_first", {31'h0, instr_valid, pc_out}, {31'h0, 1'b1, 16'h0100});
        run_cycles(10);

        // 4: back-to-back redirects, only the second survives
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 16'h0040;
        @(negedge clk);
        redirect_pc = 16'h0080;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        #2 chk("t4_first", {31'h0, instr_valid, pc_out}, {31'h0, 1'b1, 16'h0080});
        @(negedge clk);
        #2 chk("t4_second", 48'(pc_out), 48'h0081);
        run_cycles(8);

        // 5: PC wrap at 0xFFFF
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        #2 chk("t5_ffff", {31'h0, instr_valid, pc_out}, {31'h0, 1'b1, 16'hFFFF});
        @(negedge clk);
        #2 chk("t5_wrap", {31'h0, instr_valid, pc_out}, {31'h0, 1'b1, 16'h0000});
        run_cycles(8);

        // 6: five cycles of backpressure with a full pipe
        @(negedge clk);
        instr_ready = 1'b0;
`ifdef FETCH_STALL_CNT_EN
        #2 stall_base = stall_cnt;
`endif
        run_cycles(4);
        @(negedge clk);
        instr_ready = 1'b1;
        run_cycles(2);
`ifdef FETCH_STALL_CNT_EN
        #2 chk("t6_stall5", 48'(stall_cnt - stall_base), 48'(5));
        run_cycles(3);
        #2 chk("t6_hold", 48'(stall_cnt - stall_base), 48'(5));
`endif
        run_cycles(6);

        // 7: asynchronous reset mid-stream
        @(negedge clk);
        #2 chk("t7_pre_valid", 48'(instr_valid), 48'(1));
        #1 rst = 1'b1;
        #1 chk("t7_async", {14'h0, instr_valid, imem_req, instr_out}, 48'(0));
        chk("t7_pc", 48'(pc_out), 48'(0));
        run_cycles(2);
        @(negedge clk);
        rst = 1'b0;
        #2 chk("t7_restart", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 16'h0000});
        run_cycles(12);

        // drain: stop fetching, everything buffered must come out
        @(negedge clk);
        fetch_en = 1'b0;
        for (int i = 0; i < 20 && instr_valid; i++) @(negedge clk);
        run_cycles(2);
        #2 chk("drain_valid", 48'(instr_valid), 48'(0));
        chk("drain_queue", 48'(exp_q.size()), 48'(0));
        chk("drain_req", 48'(imem_req), 48'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
